// File: rtl/mem_dump_pkg.sv
// Shared constants for the post-run memory dump reader: FSM encodings and
// default widths.
package mem_dump_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_W      = $clog2(RD_LAT_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_HALT = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_RD   = 3'd3;
  localparam logic [2:0] S_PRESENT   = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

endpackage

// File: rtl/mem_dump_reader.sv
// Sweeps an inclusive address window of unified memory through the testbench
// memory port after the computer halts, streaming {addr, data} words out.
//
// state     | meaning
// IDLE      | waiting for start; window not latched
// WAIT_HALT | window latched, waiting for computer Done
// ISSUE     | mem_addr driven with current address
// WAIT_RD   | counting down read latency, capture at zero
// PRESENT   | word held on dout_* until handshake
// FINISH    | one-cycle dump_done pulse
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = 1,
  parameter int WAIT_HALT = 1
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          halt_in,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_sel,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW-1:0] dout_addr,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
  output logic          busy,
  output logic          dump_done
);

  logic [2:0]      state_q, state_d;
  logic [AW-1:0]   cur_q, cur_d;
  logic [AW-1:0]   last_q, last_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [AW-1:0]   mem_addr_q;
  logic [AW-1:0]   dout_addr_q;
  logic [DW-1:0]   dout_data_q;
  logic            dout_last_q;
  logic            capture;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          last_d  = end_addr;
          state_d = (WAIT_HALT != 0) ? S_WAIT_HALT : S_ISSUE;
        end
      end
      S_WAIT_HALT: begin
        if (halt_in) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        lat_d   = LAT_W'(RD_LAT - 1);
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == '0) state_d = S_PRESENT;
        else             lat_d   = lat_q - 1'b1;
      end
      S_PRESENT: begin
        if (dout_ready) begin
          if (cur_q == last_q) begin
            state_d = S_FINISH;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign capture = (state_q == S_WAIT_RD) && (lat_q == '0);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      dout_addr_q <= '0;
      dout_data_q <= '0;
      dout_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
      // Address is registered on entry so it is already valid during ISSUE.
      if (state_d == S_ISSUE) mem_addr_q <= cur_d;
      if (capture) begin
        dout_addr_q <= cur_q;
        dout_data_q <= mem_rdata;
        dout_last_q <= (cur_q == last_q);
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = 1'b0;
  assign mem_sel    = (state_q == S_ISSUE) || (state_q == S_WAIT_RD) ||
                      (state_q == S_PRESENT);
  assign dout_valid = (state_q == S_PRESENT);
  assign dout_addr  = dout_addr_q;
  assign dout_data  = dout_data_q;
  assign dout_last  = dout_last_q & dout_valid;
  assign busy       = (state_q != S_IDLE);
  assign dump_done  = (state_q == S_FINISH);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a registered one-cycle memory model.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        Rst, start, halt_in, dout_ready;
  logic [7:0]  start_addr, end_addr, mem_addr, dout_addr;
  logic [15:0] mem_rdata, dout_data;
  logic        mem_we, mem_sel, dout_valid, dout_last, busy, dump_done;

  logic [15:0] mem [256];
  int total = 0;
  int bad   = 0;

  mem_dump_reader #(.AW(8), .DW(16), .RD_LAT(1), .WAIT_HALT(1)) dut (
    .clk(clk), .Rst(Rst), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .halt_in(halt_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_sel(mem_sel),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_addr(dout_addr),
    .dout_data(dout_data), .dout_last(dout_last), .busy(busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_mem_addr"},   32'(mem_addr),   0);
    chk({p, "_mem_we"},     32'(mem_we),     0);
    chk({p, "_mem_sel"},    32'(mem_sel),    0);
    chk({p, "_dout_valid"}, 32'(dout_valid), 0);
    chk({p, "_dout_addr"},  32'(dout_addr),  0);
    chk({p, "_dout_data"},  32'(dout_data),  0);
    chk({p, "_dout_last"},  32'(dout_last),  0);
    chk({p, "_busy"},       32'(busy),       0);
    chk({p, "_dump_done"},  32'(dump_done),  0);
  endtask

  task automatic pulse_start(input logic [7:0] sa, input logic [7:0] ea);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Consume n words starting at sa, checking order, data, last flag, stall
  // stability and the single dump_done pulse.
  task automatic collect(input logic [7:0] sa, input int n, input bit rnd,
                         input bit inject, input bit chk_lat);
    int idx = 0;
    int cyc = 0;
    int dones = 0;
    int last_acc = -1;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0]  pa = '0, ea;
    logic [15:0] pd = '0;
    while (idx < n && cyc < 400) begin
      if (dump_done) dones++;
      chk("mem_we_low", 32'(mem_we), 0);
      if (pv && !pr) begin
        chk("stall_valid", 32'(dout_valid), 1);
        chk("stall_addr",  32'(dout_addr),  32'(pa));
        chk("stall_data",  32'(dout_data),  32'(pd));
        chk("stall_last",  32'(dout_last),  32'(pl));
      end
      start = inject && (cyc == 1);
      if (inject && cyc == 1) begin
        start_addr = 8'h80;
        end_addr   = 8'h84;
      end
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dout_valid && dout_ready) begin
        ea = sa + 8'(idx);
        chk("word_addr", 32'(dout_addr), 32'(ea));
        chk("word_data", 32'(dout_data), 32'(mem[ea]));
        chk("word_last", 32'(dout_last), (idx == n - 1) ? 1 : 0);
        chk("word_sel",  32'(mem_sel),   1);
        if (chk_lat && last_acc >= 0) chk("word_gap", 32'(cyc - last_acc), 3);
        last_acc = cyc;
        idx++;
      end
      pv = dout_valid; pr = dout_ready; pa = dout_addr; pd = dout_data; pl = dout_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (idx < n) chk("collect_timeout", 32'(idx), 32'(n));
    repeat (6) begin
      if (dump_done) dones++;
      @(negedge clk);
    end
    chk("dump_done_count", 32'(dones), 1);
    chk("busy_after", 32'(busy), 0);
    chk("valid_after", 32'(dout_valid), 0);
  endtask

  initial begin
    bit found;
    Rst = 1'b1; start = 1'b0; halt_in = 1'b1; dout_ready = 1'b1;
    start_addr = '0; end_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h80] = 16'h0001; mem[8'h81] = 16'h0021; mem[8'h82] = 16'h00A0;
    mem[8'h83] = 16'h000D; mem[8'h84] = 16'h0700;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    Rst = 1'b0;
    @(negedge clk);

    // Basic window, ready held high, 3-cycle per-word cadence.
    pulse_start(8'h80, 8'h84);
    collect(8'h80, 5, 1'b0, 1'b0, 1'b1);

    // Start while computer not yet done: no memory access until halt_in.
    halt_in = 1'b0;
    pulse_start(8'h80, 8'h84);
    repeat (8) begin
      chk("nohalt_sel",   32'(mem_sel),    0);
      chk("nohalt_valid", 32'(dout_valid), 0);
      chk("nohalt_busy",  32'(busy),       1);
      @(negedge clk);
    end
    halt_in = 1'b1;
    collect(8'h80, 5, 1'b0, 1'b0, 1'b0);

    // Wrapping window FE..01 is four words.
    mem[8'hFE] = 16'hAAAA; mem[8'hFF] = 16'hBBBB;
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'h5678;
    pulse_start(8'hFE, 8'h01);
    collect(8'hFE, 4, 1'b0, 1'b0, 1'b0);

    // Random backpressure.
    pulse_start(8'h80, 8'h84);
    collect(8'h80, 5, 1'b1, 1'b0, 1'b0);

    // Single-word window with a second start injected while busy.
    pulse_start(8'h83, 8'h83);
    collect(8'h83, 1, 1'b0, 1'b1, 1'b0);

    // Reset while word 82 is presented and stalled.
    dout_ready = 1'b1;
    pulse_start(8'h80, 8'h84);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (dout_valid && dout_addr == 8'h82) begin
        dout_ready = 1'b0;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("reach_82", 32'(found), 1);
    @(negedge clk);
    chk("stalled_82_valid", 32'(dout_valid), 1);
    chk("stalled_82_addr",  32'(dout_addr),  32'h82);
    #2 Rst = 1'b1;
    #1 chk_reset("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(dump_done), 0);
    end
    Rst = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    pulse_start(8'h80, 8'h80);
    collect(8'h80, 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
